irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_if.sv | 16 +
 rtl/irq_prio_enc.sv | 26 ++
 rtl/irq_controller.sv | 131 +++++++++++++
 tb/tb_irq_controller.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
// Contents:
//   irq_state_t      - arbitration FSM states (IDLE, REQ, GAP)
//   DEFAULT_CHANNELS - default number of interrupt sources
package irq_pkg;

    localparam int DEFAULT_CHANNELS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_if.sv
// rtl/irq_if.sv - interrupt handshake between controller and core
// Signals:
//   intr - interrupt request to core (controller drives)
//   vect - vector number of the presented channel (controller drives)
//   ack  - one-cycle pulse from core, current vector accepted (core drives)
// Modports: master = controller side, slave = core side.
interface irq_if #(
    parameter int VECT_W = 3
) ();
    logic              intr;
    logic [VECT_W-1:0] vect;
    logic              ack;

    modport master (output intr, output vect, input ack);
    modport slave  (input intr, input vect, output ack);
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational fixed-priority encoder, lowest index wins
// Ports:
//   req   in  CHANNELS  request vector
//   valid out 1         any request set
//   idx   out IDX_W     index of the lowest set request (0 when none)
module irq_prio_enc #(
    parameter int CHANNELS = 8,
    parameter int IDX_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    output logic                valid,
    output logic [IDX_W-1:0]    idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downwards so the last hit, and therefore the winner, is the lowest index.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - vectored interrupt controller with edge/level sources
// Ports:
//   clock     in  1         single clock, rising edge
//   reset_n   in  1         asynchronous active-low reset
//   irq_i     in  CHANNELS  raw interrupt lines
//   mode_i    in  CHANNELS  per channel: 1 = rising edge, 0 = level high
//   mask_i    in  CHANNELS  per channel: 1 = enabled
//   core      irq_if.master intr / vect / ack handshake with the core
//   pending_o out CHANNELS  pending register
// Build option: IRQ_SYNC_EN selects a two-flop input synchroniser; without it
// a single register stage is used and irq_i must be synchronous to clock.
// Note: previous-sample flops reset to 0, so a line already high at reset
// release produces exactly one edge event on its first synced high sample.
module irq_controller
    import irq_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int VECT_W   = $clog2(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] irq_i,
    input  logic [CHANNELS-1:0] mode_i,
    input  logic [CHANNELS-1:0] mask_i,
    irq_if.master               core,
    output logic [CHANNELS-1:0] pending_o
);

    logic [CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] pending_d;
    logic [CHANNELS-1:0] edge_evt;
    logic [CHANNELS-1:0] ack_clr;
    logic [VECT_W-1:0]   vect_q;
    logic                win_valid;
    logic [VECT_W-1:0]   win_idx;
    irq_state_t          state_q;
    irq_state_t          state_d;

`ifdef IRQ_SYNC_EN
    logic [CHANNELS-1:0] meta_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= irq_i;
            sync_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= irq_i;
        end
    end
`endif

    assign edge_evt = sync_q & ~prev_q;

    // Only edge-mode bits are cleared by ack; level bits follow the line.
    assign ack_clr = (state_q == REQ && core.ack)
                   ? ((CHANNELS'(1) << vect_q) & mode_i) : '0;

    // A new edge in the same cycle as its ack clear keeps the bit pending.
    assign pending_d = (mode_i & (edge_evt | (pending_q & ~ack_clr)))
                     | (~mode_i & sync_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= sync_q;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

    irq_prio_enc #(
        .CHANNELS (CHANNELS),
        .IDX_W    (VECT_W)
    ) u_prio_enc (
        .req   (pending_q & mask_i),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Winner is frozen on entry to REQ so later arrivals or mask changes
    // cannot disturb the vector the core is about to read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vect_q <= '0;
        end else if (state_q == IDLE && win_valid) begin
            vect_q <= win_idx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = REQ;
            REQ:     if (core.ack)  state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core.intr = 1'b0;
        core.vect = '0;
        if (state_q == REQ) begin
            core.intr = 1'b1;
            core.vect = vect_q;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller (CHANNELS=8)
module tb_irq_controller;
    import irq_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] irq_i = '0;
    logic [7:0] mode_i = 8'hFF;
    logic [7:0] mask_i = 8'hFF;
    logic [7:0] pending_o;

    int total = 0;
    int bad = 0;
    logic [2:0] sb[$];

    irq_if #(.VECT_W(3)) core ();

    irq_controller #(.CHANNELS(8), .VECT_W(3)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .irq_i     (irq_i),
        .mode_i    (mode_i),
        .mask_i    (mask_i),
        .core      (core),
        .pending_o (pending_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a request, compares against the scoreboard head,
    // acknowledges it and checks the following GAP cycle.
    task automatic serve(input string tag);
        int n;
        logic [2:0] exp;
        n = 0;
        while (core.intr !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_intr"}, {31'd0, core.intr}, 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 3'bxxx;
        check({tag, "_vect"}, {29'd0, core.vect}, {29'd0, exp});
        core.ack = 1'b1;
        tick();
        core.ack = 1'b0;
        check({tag, "_gap_intr"}, {31'd0, core.intr}, 32'd0);
        check({tag, "_gap_vect"}, {29'd0, core.vect}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        core.ack = 1'b0;

        // Reset state
        tick();
        check("rst_intr", {31'd0, core.intr}, 32'd0);
        check("rst_vect", {29'd0, core.vect}, 32'd0);
        check("rst_pend", {24'd0, pending_o}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single edge pulse on ch5: exact latency, then ack, stays idle
        irq_i = 8'h20;
        sb.push_back(3'd5);
        tick();
        irq_i = 8'h00;
        repeat (LAT - 1) tick();
        check("lat_early", {31'd0, core.intr}, 32'd0);
        tick();
        check("lat_intr", {31'd0, core.intr}, 32'd1);
        serve("ch5");
        check("ch5_pend", {24'd0, pending_o}, 32'd0);
        repeat (3) begin
            tick();
            check("ch5_idle", {31'd0, core.intr}, 32'd0);
        end

        // Simultaneous ch6 and ch2: priority order
        irq_i = 8'h44;
        sb.push_back(3'd2);
        sb.push_back(3'd6);
        tick();
        irq_i = 8'h00;
        serve("pri_a");
        serve("pri_b");
        tick();
        check("pri_idle", {31'd0, core.intr}, 32'd0);
        check("pri_pend", {24'd0, pending_o}, 32'd0);

        // Higher-priority arrival during REQ does not preempt
        irq_i = 8'h10;
        sb.push_back(3'd4);
        sb.push_back(3'd0);
        tick();
        irq_i = 8'h00;
        repeat (LAT) tick();
        check("hold_req", {31'd0, core.intr}, 32'd1);
        irq_i = 8'h01;
        tick();
        irq_i = 8'h00;
        mask_i = 8'hEF;
        repeat (LAT + 1) begin
            tick();
            check("hold_intr", {31'd0, core.intr}, 32'd1);
            check("hold_vect", {29'd0, core.vect}, 32'd4);
        end
        mask_i = 8'hFF;
        check("hold_pend", {24'd0, pending_o}, 32'h11);
        serve("hold_a");
        serve("hold_b");

        // Level mode on ch3: re-request every third cycle while high
        tick();
        mode_i = 8'hF7;
        irq_i = 8'h08;
        sb.push_back(3'd3);
        serve("lvl");
        for (int r = 0; r < 3; r++) begin
            tick();
            check("lvl_idle", {31'd0, core.intr}, 32'd0);
            tick();
            check("lvl_intr", {31'd0, core.intr}, 32'd1);
            check("lvl_vect", {29'd0, core.vect}, 32'd3);
            core.ack = 1'b1;
            if (r == 2) irq_i = 8'h00;
            tick();
            core.ack = 1'b0;
            check("lvl_gap", {31'd0, core.intr}, 32'd0);
        end
        repeat (5) begin
            tick();
            check("lvl_drop", {31'd0, core.intr}, 32'd0);
        end
        check("lvl_pend", {24'd0, pending_o}, 32'd0);
        mode_i = 8'hFF;

        // Masked channel stays pending; ack while idle is ignored
        mask_i = 8'hFD;
        irq_i = 8'h02;
        tick();
        irq_i = 8'h00;
        repeat (LAT + 2) tick();
        check("mask_intr", {31'd0, core.intr}, 32'd0);
        check("mask_pend", {24'd0, pending_o}, 32'h02);
        core.ack = 1'b1;
        tick();
        core.ack = 1'b0;
        check("idle_ack_pend", {24'd0, pending_o}, 32'h02);
        mask_i = 8'hFF;
        sb.push_back(3'd1);
        tick();
        check("unmask_intr", {31'd0, core.intr}, 32'd1);
        check("unmask_vect", {29'd0, core.vect}, 32'd1);
        serve("unmask");

        // Asynchronous reset while a request is presented
        tick();
        irq_i = 8'h0C;
        tick();
        irq_i = 8'h00;
        repeat (LAT) tick();
        check("pre_rst_intr", {31'd0, core.intr}, 32'd1);
        check("pre_rst_vect", {29'd0, core.vect}, 32'd2);
        check("pre_rst_pend", {24'd0, pending_o}, 32'h0C);
        reset_n = 1'b0;
        #1;
        check("arst_intr", {31'd0, core.intr}, 32'd0);
        check("arst_vect", {29'd0, core.vect}, 32'd0);
        check("arst_pend", {24'd0, pending_o}, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (4) begin
            tick();
            check("post_rst_intr", {31'd0, core.intr}, 32'd0);
        end

        check("sb_drain", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
